// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: cache-bus SRAM responder (clk, resetn async active-low, creq in, cresp out; LATENCY idle cycles before first beat)
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2;
  logic [1:0]    state;
  logic [AW-1:0] base, idx;
  logic [3:0]    len, beat;
  logic          wr, burst, we;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [MEM_WORDS];
  logic          unused;
  assign unused = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};
  assign burst = state == BURST;
  assign idx = base + AW'(beat);
  assign we = burst && wr && creq.valid;
  assign cresp.ready = burst;
  assign cresp.last = burst && beat == len;
  assign cresp.data = burst && !wr ? mem[idx] : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      beat  <= '0;
      cnt   <= '0;
      base  <= '0;
      len   <= '0;
      wr    <= 1'b0;
    end else if (state == IDLE) begin
      if (creq.valid) begin
        base  <= creq.addr[AW+1:2];
        len   <= creq.len;
        wr    <= creq.is_write;
        beat  <= '0;
        cnt   <= CW'(LATENCY - 1);
        state <= LATENCY == 0 ? BURST : WAIT;
      end
    end else if (!creq.valid) begin
      state <= IDLE;
    end else if (state == WAIT) begin
      cnt   <= cnt - 1'b1;
      state <= cnt == '0 ? BURST : WAIT;
    end else if (beat == len) begin
      state <= IDLE;
    end else begin
      beat <= beat + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (creq.strobe[b]) mem[idx][8*b +: 8] <= creq.data[8*b +: 8];
  end
endmodule
